// File: rtl/unified_memory_arbiter_if.sv
// Fetch, data and memory-side signals of the unified memory arbiter.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface unified_memory_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 7
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic                  if_rvalid;
  logic [XLEN-1:0]       if_rdata;

  logic                  dm_req;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [XLEN-1:0]       dm_wdata;
  logic [3:0]            dm_read_byte_en;
  logic [3:0]            dm_write_byte_en;
  logic                  dm_ready;
  logic                  dm_rvalid;
  logic [XLEN-1:0]       dm_rdata;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [XLEN-1:0]       mem_data_in;
  logic [3:0]            mem_read_byte_en;
  logic [3:0]            mem_write_byte_en;
  logic [XLEN-1:0]       mem_data_out;

  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_read_byte_en,
           dm_write_byte_en, mem_data_out,
    output if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
           mem_address, mem_data_in, mem_read_byte_en, mem_write_byte_en
  );

  modport master (
    output if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_read_byte_en,
           dm_write_byte_en, mem_data_out,
    input  if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
           mem_address, mem_data_in, mem_read_byte_en, mem_write_byte_en
  );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access, one access in flight.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed data priority.
//
//   state | meaning
//   IDLE  | no access in flight; a pending request is granted this cycle
//   BUSY  | address held to memory for MEM_LATENCY cycles; last cycle captures data / writes
//   RESP  | owner's rvalid pulses; no grant issued
module unified_memory_arbiter #(
  parameter int XLEN        = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  unified_memory_arbiter_if.slave  bus
);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("unified_memory_arbiter: MEM_LATENCY must be >= 1");
  end

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t                state;
  owner_t                owner;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [3:0]            rbe_q;
  logic [3:0]            wbe_q;
  logic                  is_write;
  logic                  if_rvalid_q;
  logic                  dm_rvalid_q;
  logic [XLEN-1:0]       if_rdata_q;
  logic [XLEN-1:0]       dm_rdata_q;
  logic                  can_grant;
  logic                  grant_dm;
  logic                  grant_if;

  // Ready is suppressed while reset is held so every output reads 0 during reset.
  assign can_grant = (state == IDLE) && !reset;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;

  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (can_grant) begin
      if (bus.dm_req && bus.if_req) begin
        grant_dm = (last_owner == OWN_FETCH);
        grant_if = (last_owner == OWN_DATA);
      end else begin
        grant_dm = bus.dm_req;
        grant_if = bus.if_req;
      end
    end
  end
`else
  assign grant_dm = can_grant && bus.dm_req;
  assign grant_if = can_grant && bus.if_req && !bus.dm_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_FETCH;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbe_q       <= '0;
      wbe_q       <= '0;
      is_write    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner  <= OWN_FETCH;
`endif
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            owner    <= OWN_DATA;
            addr_q   <= bus.dm_addr;
            wdata_q  <= bus.dm_wdata;
            rbe_q    <= bus.dm_read_byte_en;
            wbe_q    <= bus.dm_write_byte_en;
            is_write <= |bus.dm_write_byte_en;
            cnt      <= CNT_W'(MEM_LATENCY - 1);
            state    <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= OWN_DATA;
`endif
          end else if (grant_if) begin
            owner    <= OWN_FETCH;
            addr_q   <= bus.if_addr;
            wdata_q  <= '0;
            rbe_q    <= 4'b1111;
            wbe_q    <= 4'b0000;
            is_write <= 1'b0;
            cnt      <= CNT_W'(MEM_LATENCY - 1);
            state    <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= OWN_FETCH;
`endif
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (owner == OWN_DATA) begin
              dm_rdata_q  <= is_write ? '0 : bus.mem_data_out;
              dm_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= bus.mem_data_out;
              if_rvalid_q <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_ready          = grant_if;
  assign bus.dm_ready          = grant_dm;
  assign bus.if_rvalid         = if_rvalid_q;
  assign bus.dm_rvalid         = dm_rvalid_q;
  assign bus.if_rdata          = if_rdata_q;
  assign bus.dm_rdata          = dm_rdata_q;
  assign bus.mem_address       = addr_q;
  assign bus.mem_data_in       = wdata_q;
  assign bus.mem_read_byte_en  = (state == BUSY) ? rbe_q : 4'b0000;
  // Write strobe only on the last BUSY cycle, so a reset earlier in the access never writes.
  assign bus.mem_write_byte_en = (state == BUSY && cnt == '0 && is_write) ? wbe_q : 4'b0000;

endmodule
